// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch -> decode instruction queue.
// A fetch packet is {hit, predBJ, pc, instr}, 66 bits, hit in the MSB.
package fetch_pkg;

  localparam int FETCH_ENTRY_W = 66;
  localparam int HIT_BIT       = 65;
  localparam int PRED_BIT      = 64;
  localparam int PC_MSB        = 63;
  localparam int PC_LSB        = 32;
  localparam int INSTR_MSB     = 31;
  localparam int INSTR_LSB     = 0;

  typedef struct packed {
    logic        hit;
    logic        pred_bj;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue_ctrl_if.sv
// Handshake bundle between fetch/decode (master) and the fetch queue (slave).
interface fetch_queue_ctrl_if
  import fetch_pkg::*;
#(
  parameter int ENTRY_W = FETCH_ENTRY_W,
  parameter int PTR_W   = 3
);
  logic               flush;
  logic [1:0]         enq_vld;
  logic [ENTRY_W-1:0] enq_data1;
  logic [ENTRY_W-1:0] enq_data2;
  logic               stall_F;
  logic [1:0]         deq_rdy;
  logic [1:0]         deq_vld;
  logic [ENTRY_W-1:0] deq_data1;
  logic [ENTRY_W-1:0] deq_data2;
  logic [PTR_W:0]     count;

  modport master (
    output flush, enq_vld, enq_data1, enq_data2, deq_rdy,
    input  stall_F, deq_vld, deq_data1, deq_data2, count
  );

  modport slave (
    input  flush, enq_vld, enq_data1, enq_data2, deq_rdy,
    output stall_F, deq_vld, deq_data1, deq_data2, count
  );
endinterface

// File: rtl/fq_checker.sv
// Simulation checks on the slot-pair encoding of the enqueue/dequeue handshakes.
module fq_checker (
  input logic       clk,
  input logic       reset,
  input logic [1:0] enq_vld,
  input logic [1:0] deq_rdy
);

  a_enq_pair: assert property (@(posedge clk) disable iff (!reset) enq_vld != 2'b10)
    else $error("fq_checker: enq_vld=10 is illegal");

  a_deq_pair: assert property (@(posedge clk) disable iff (!reset) deq_rdy != 2'b10)
    else $error("fq_checker: deq_rdy=10 is illegal");

endmodule

// File: rtl/fq_regfile.sv
// Queue storage: two write ports (tail, tail+1) and two asynchronous read
// ports (head, head+1). The two write addresses are always distinct.
module fq_regfile #(
  parameter int ENTRY_W = 66,
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3
) (
  input  logic               clk,
  input  logic               we0,
  input  logic [PTR_W-1:0]   wa0,
  input  logic [ENTRY_W-1:0] wd0,
  input  logic               we1,
  input  logic [PTR_W-1:0]   wa1,
  input  logic [ENTRY_W-1:0] wd1,
  input  logic [PTR_W-1:0]   ra0,
  output logic [ENTRY_W-1:0] rd0,
  input  logic [PTR_W-1:0]   ra1,
  output logic [ENTRY_W-1:0] rd1
);

  logic [ENTRY_W-1:0] mem_r [DEPTH];

  // Storage write; contents need no reset since validity is tracked by count
  always_ff @(posedge clk) begin
    if (we0) begin
      mem_r[wa0] <= wd0;
    end
    if (we1) begin
      mem_r[wa1] <= wd1;
    end
  end

  assign rd0 = mem_r[ra0];
  assign rd1 = mem_r[ra1];

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Dual-issue fetch queue controller: up to two packets in and out per cycle,
// program order preserved, slot 2 squashed behind a predicted-taken slot 1.
module fetch_queue_ctrl
  import fetch_pkg::*;
#(
  parameter  int ENTRY_W = FETCH_ENTRY_W,
  parameter  int DEPTH   = 8,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               reset,
  fetch_queue_ctrl_if.slave fq
);

  localparam logic [PTR_W:0]   STALL_LVL = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_TWO   = (PTR_W+1)'(2);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [PTR_W:0]     count_r;

  logic               stall_s;
  logic               taken1_s;
  logic               enq_w0_s;
  logic               enq_w1_s;
  logic               deq_t0_s;
  logic               deq_t1_s;
  logic [1:0]         deq_vld_s;
  logic [PTR_W:0]     enq_n_s;
  logic [PTR_W:0]     deq_n_s;
  logic [ENTRY_W-1:0] rd0_s;
  logic [ENTRY_W-1:0] rd1_s;

  // Handshake decode; an enq_vld/deq_rdy of 10 yields no transfer at all
  always_comb begin
    stall_s   = (count_r > STALL_LVL);
    taken1_s  = fq.enq_data1[ENTRY_W-1] & fq.enq_data1[ENTRY_W-2];
    enq_w0_s  = ~stall_s & ~fq.flush & fq.enq_vld[0];
    enq_w1_s  = enq_w0_s & fq.enq_vld[1] & ~taken1_s;
    deq_vld_s = {(count_r >= CNT_TWO), (count_r >= CNT_ONE)};
    deq_t0_s  = deq_vld_s[0] & fq.deq_rdy[0];
    deq_t1_s  = deq_vld_s[1] & fq.deq_rdy[1] & fq.deq_rdy[0];
    enq_n_s   = {{PTR_W{1'b0}}, enq_w0_s} + {{PTR_W{1'b0}}, enq_w1_s};
    deq_n_s   = {{PTR_W{1'b0}}, deq_t0_s} + {{PTR_W{1'b0}}, deq_t1_s};
  end

  // Pointer and occupancy update; reset dominates flush, flush dominates traffic
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(PTR_W+1){1'b0}};
    end else if (fq.flush) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(PTR_W+1){1'b0}};
    end else begin
      head_r  <= head_r + deq_n_s[PTR_W-1:0];
      tail_r  <= tail_r + enq_n_s[PTR_W-1:0];
      count_r <= count_r + enq_n_s - deq_n_s;
    end
  end

  fq_regfile #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W)
  ) u_regfile (
    .clk (clk),
    .we0 (enq_w0_s),
    .wa0 (tail_r),
    .wd0 (fq.enq_data1),
    .we1 (enq_w1_s),
    .wa1 (tail_r + PTR_ONE),
    .wd1 (fq.enq_data2),
    .ra0 (head_r),
    .rd0 (rd0_s),
    .ra1 (head_r + PTR_ONE),
    .rd1 (rd1_s)
  );

  fq_checker u_checker (
    .clk     (clk),
    .reset   (reset),
    .enq_vld (fq.enq_vld),
    .deq_rdy (fq.deq_rdy)
  );

  assign fq.stall_F   = stall_s;
  assign fq.deq_vld   = deq_vld_s;
  assign fq.deq_data1 = rd0_s;
  assign fq.deq_data2 = rd1_s;
  assign fq.count     = count_r;

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Self-checking bench for fetch_queue_ctrl: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_fetch_queue_ctrl;
  import fetch_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic clk;
  logic reset;

  fetch_queue_ctrl_if #(.ENTRY_W(FETCH_ENTRY_W), .PTR_W(PTR_W)) fq ();

  fetch_queue_ctrl #(.ENTRY_W(FETCH_ENTRY_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_n = 0;
  int fails_n  = 0;
  logic [FETCH_ENTRY_W-1:0] model_q [$];

  // Single comparison point
  task automatic chk(input string tag, input logic [FETCH_ENTRY_W-1:0] got,
                     input logic [FETCH_ENTRY_W-1:0] exp);
    checks_n++;
    if (got !== exp) begin
      fails_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FETCH_ENTRY_W-1:0] mk(input logic h, input logic p,
                                                  input logic [31:0] pc);
    logic [31:0] ins;
    ins = $urandom();
    return {h, p, pc, ins};
  endfunction

  function automatic logic [31:0] pc_of(input logic [FETCH_ENTRY_W-1:0] e);
    return e[PC_MSB:PC_LSB];
  endfunction

  // Compare outputs with the model, advance the model, then one clock
  task automatic tick();
    int n;
    int pops;
    bit stl;
    n   = model_q.size();
    stl = (n > DEPTH - 2);
    chk("count", FETCH_ENTRY_W'(fq.count), FETCH_ENTRY_W'(n));
    chk("stall_F", FETCH_ENTRY_W'(fq.stall_F), FETCH_ENTRY_W'(stl));
    chk("deq_vld", FETCH_ENTRY_W'(fq.deq_vld), FETCH_ENTRY_W'({n >= 2, n >= 1}));
    if (n >= 1) chk("deq_data1", fq.deq_data1, model_q[0]);
    if (n >= 2) chk("deq_data2", fq.deq_data2, model_q[1]);
    if (!reset || fq.flush) begin
      model_q.delete();
    end else begin
      pops = 0;
      if (n >= 1 && fq.deq_rdy[0]) pops = 1;
      if (n >= 2 && fq.deq_rdy == 2'b11) pops = 2;
      for (int k = 0; k < pops; k++) void'(model_q.pop_front());
      if (!stl && fq.enq_vld[0]) begin
        model_q.push_back(fq.enq_data1);
        if (fq.enq_vld[1] && !(fq.enq_data1[HIT_BIT] && fq.enq_data1[PRED_BIT]))
          model_q.push_back(fq.enq_data2);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] ev, input logic [FETCH_ENTRY_W-1:0] d1,
                       input logic [FETCH_ENTRY_W-1:0] d2, input logic [1:0] rdy,
                       input logic fl);
    fq.enq_vld   = ev;
    fq.enq_data1 = d1;
    fq.enq_data2 = d2;
    fq.deq_rdy   = rdy;
    fq.flush     = fl;
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && model_q.size() > 0; k++) begin
      drive(2'b00, '0, '0, 2'b11, 1'b0);
      tick();
    end
    chk("drained", FETCH_ENTRY_W'(fq.count), '0);
  endtask

  initial begin
    int s;
    int r;
    logic [31:0] base;
    logic [1:0] ev;
    logic [1:0] rdy;

    // Reset held two cycles with traffic offered
    reset = 1'b0;
    fq.enq_vld   = 2'b11;
    fq.enq_data1 = mk(1'b0, 1'b0, 32'h0);
    fq.enq_data2 = mk(1'b0, 1'b0, 32'h4);
    fq.deq_rdy   = 2'b00;
    fq.flush     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_count", FETCH_ENTRY_W'(fq.count), '0);
    chk("rst_deq_vld", FETCH_ENTRY_W'(fq.deq_vld), '0);
    chk("rst_stall", FETCH_ENTRY_W'(fq.stall_F), '0);
    reset = 1'b1;

    // Fill: five pairs offered, the fifth is blocked by stall_F
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, mk(1'b0, 1'b0, 32'(8 * i)), mk(1'b0, 1'b0, 32'(8 * i + 4)), 2'b00, 1'b0);
      tick();
    end
    chk("fill_count", FETCH_ENTRY_W'(fq.count), FETCH_ENTRY_W'(8));
    chk("fill_stall", FETCH_ENTRY_W'(fq.stall_F), FETCH_ENTRY_W'(1));
    chk("fill_head_pc", FETCH_ENTRY_W'(pc_of(fq.deq_data1)), '0);
    drain();

    // Predicted-taken slot 1 squashes slot 2
    drive(2'b11, mk(1'b1, 1'b1, 32'h200), mk(1'b0, 1'b0, 32'h204), 2'b00, 1'b0);
    tick();
    drive(2'b00, '0, '0, 2'b00, 1'b0);
    #1;
    chk("taken_count", FETCH_ENTRY_W'(fq.count), FETCH_ENTRY_W'(1));
    chk("taken_vld", FETCH_ENTRY_W'(fq.deq_vld), FETCH_ENTRY_W'(2'b01));
    tick();
    drain();

    // Concurrent enqueue and dequeue at count 4
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, mk(1'b0, 1'b0, 32'(32'h300 + 8 * i)), mk(1'b0, 1'b0, 32'(32'h304 + 8 * i)), 2'b00, 1'b0);
      tick();
    end
    drive(2'b11, mk(1'b0, 1'b0, 32'h310), mk(1'b0, 1'b0, 32'h314), 2'b11, 1'b0);
    chk("conc_pc1", FETCH_ENTRY_W'(pc_of(fq.deq_data1)), FETCH_ENTRY_W'(32'h300));
    chk("conc_pc2", FETCH_ENTRY_W'(pc_of(fq.deq_data2)), FETCH_ENTRY_W'(32'h304));
    tick();
    drive(2'b00, '0, '0, 2'b00, 1'b0);
    chk("conc_count", FETCH_ENTRY_W'(fq.count), FETCH_ENTRY_W'(4));
    chk("conc_next_pc", FETCH_ENTRY_W'(pc_of(fq.deq_data1)), FETCH_ENTRY_W'(32'h308));
    drain();

    // Wrap: 12 sequential pcs in at two per cycle, out at one per cycle
    base = 32'h1000;
    s = 0;
    r = 0;
    for (int c = 0; c < 100 && r < 12; c++) begin
      if (s < 12)
        drive(2'b11, mk(1'b0, 1'b0, base + 32'(4 * s)), mk(1'b0, 1'b0, base + 32'(4 * s + 4)), 2'b01, 1'b0);
      else
        drive(2'b00, '0, '0, 2'b01, 1'b0);
      if (model_q.size() >= 1) begin
        chk("wrap_seq", FETCH_ENTRY_W'(pc_of(fq.deq_data1)), FETCH_ENTRY_W'(base + 32'(4 * r)));
        r++;
      end
      if (s < 12 && model_q.size() <= DEPTH - 2) s += 2;
      tick();
    end
    chk("wrap_done", FETCH_ENTRY_W'(r), FETCH_ENTRY_W'(12));
    drain();

    // Flush at count 5 with simultaneous enqueue and dequeue
    drive(2'b11, mk(1'b0, 1'b0, 32'h400), mk(1'b0, 1'b0, 32'h404), 2'b00, 1'b0);
    tick();
    drive(2'b11, mk(1'b0, 1'b0, 32'h408), mk(1'b0, 1'b0, 32'h40c), 2'b00, 1'b0);
    tick();
    drive(2'b01, mk(1'b0, 1'b0, 32'h410), '0, 2'b00, 1'b0);
    tick();
    drive(2'b11, mk(1'b0, 1'b0, 32'h414), mk(1'b0, 1'b0, 32'h418), 2'b11, 1'b1);
    chk("pre_flush_count", FETCH_ENTRY_W'(fq.count), FETCH_ENTRY_W'(5));
    tick();
    drive(2'b00, '0, '0, 2'b00, 1'b0);
    chk("flush_count", FETCH_ENTRY_W'(fq.count), '0);
    chk("flush_vld", FETCH_ENTRY_W'(fq.deq_vld), '0);
    chk("flush_stall", FETCH_ENTRY_W'(fq.stall_F), '0);

    // Random traffic with occasional flush and one mid-run reset
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       ev = 2'b00;
        1:       ev = 2'b01;
        default: ev = 2'b11;
      endcase
      case ($urandom_range(0, 2))
        0:       rdy = 2'b00;
        1:       rdy = 2'b01;
        default: rdy = 2'b11;
      endcase
      reset = (i == 200) ? 1'b0 : 1'b1;
      drive(ev, mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom()),
            mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom()),
            rdy, ($urandom_range(0, 31) == 0));
      tick();
    end
    reset = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end

endmodule
